// File: rtl/inst_fetch_queue.sv
// Fetch queue: issues PC-generator addresses to instruction memory, collects in-order
// responses into a slot ring and hands {pc, inst} pairs to ID; flush discards in-flight work.
module inst_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int CPU_WIDTH  = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_valid,
    input  logic [CPU_WIDTH-1:0]  pc_addr,
    input  logic                  pc_no_use,
    output logic                  pc_ready,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [CPU_WIDTH-1:0]  mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic                  id_valid,
    output logic [CPU_WIDTH-1:0]  id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    input  logic                  id_ready,
    output logic                  empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      alloc_ptr;
    logic [PTR_W-1:0]      fill_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      drop_cnt;
    logic [PTR_W-1:0]      used;
    logic [PTR_W-1:0]      pending;
    logic [CPU_WIDTH-1:0]  slot_pc   [DEPTH];
    logic [INST_WIDTH-1:0] slot_inst [DEPTH];
    logic                  credit;
    logic                  issue;
    logic                  fill;
    logic                  drop;
    logic                  pop;

    // On redirect every pending fetch becomes a response to discard; a response
    // arriving in the same cycle already retires one of them. Saturates at zero.
    function automatic logic [PTR_W-1:0] flush_drop(input logic [PTR_W-1:0] cnt,
                                                    input logic [PTR_W-1:0] pend,
                                                    input logic             rv);
        logic [PTR_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, pend};
        if (sum == '0) begin
            return '0;
        end
        sum = sum - {{PTR_W{1'b0}}, rv};
        return sum[PTR_W-1:0];
    endfunction

    assign used    = alloc_ptr - rd_ptr;
    assign pending = alloc_ptr - fill_ptr;
    assign credit  = ({1'b0, used} + {1'b0, drop_cnt}) < DEPTH_CNT;

    assign mem_req  = pc_valid & ~pc_no_use & credit & ~flush & ~rst;
    assign mem_addr = pc_addr;
    assign pc_ready = ~rst & ~flush & pc_valid & (pc_no_use | (credit & mem_gnt));
    assign issue    = mem_req & mem_gnt;

    // Stale responses are consumed before any response is credited to a slot.
    assign drop = mem_rvalid & (drop_cnt != '0);
    assign fill = mem_rvalid & (drop_cnt == '0) & (pending != '0) & ~flush;

    assign id_valid = (fill_ptr != rd_ptr) & ~flush & ~rst;
    assign pop      = id_valid & id_ready;
    assign id_pc    = slot_pc[rd_ptr[IDX_W-1:0]];
    assign id_inst  = slot_inst[rd_ptr[IDX_W-1:0]];
    assign empty    = rst | ((used == '0) & (drop_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= flush_drop(drop_cnt, pending, mem_rvalid);
        end else begin
            if (issue) begin
                alloc_ptr <= alloc_ptr + PTR_ONE;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                drop_cnt <= drop_cnt - PTR_ONE;
            end
        end
    end

    // Slot payload carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (issue) begin
            slot_pc[alloc_ptr[IDX_W-1:0]] <= pc_addr;
        end
        if (fill) begin
            slot_inst[fill_ptr[IDX_W-1:0]] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus a randomized run scored
// against a queue-based model of slots, drops and an in-order memory.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 64;
    localparam int IW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_valid;
    logic [CW-1:0] pc_addr;
    logic          pc_no_use;
    logic          pc_ready;
    logic          flush;
    logic          mem_req;
    logic [CW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [IW-1:0] mem_rdata;
    logic          id_valid;
    logic [CW-1:0] id_pc;
    logic [IW-1:0] id_inst;
    logic          id_ready;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] m_pc[$];
    logic [IW-1:0] m_inst[$];
    int            m_drop;
    logic [IW-1:0] memq[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .CPU_WIDTH(CW), .INST_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_no_use(pc_no_use), .pc_ready(pc_ready),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        pc_valid = 0; pc_addr = '0; pc_no_use = 0; flush = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; id_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
        m_pc.delete(); m_inst.delete(); m_drop = 0; memq.delete();
    endtask

    task automatic test_reset();
        rst = 1; pc_valid = 1; pc_addr = 64'h8000_0000; mem_gnt = 1; id_ready = 1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL rst_pc_ready got %b want 0", pc_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
        next_cycle();
        rst = 0; pc_valid = 0;
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_post_empty got %b want 1", empty); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_post_id_valid got %b want 0", id_valid); end
        next_cycle();
    endtask

    task automatic test_basic();
        do_reset();
        pc_valid = 1; pc_addr = 64'h8000_0000; mem_gnt = 1; id_ready = 1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL basic_req0 got %b want 1", mem_req); end
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL basic_rdy0 got %b want 1", pc_ready); end
        n_cmp++; if (mem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL basic_addr0 got %h want 80000000", mem_addr); end
        next_cycle();
        pc_addr = 64'h8000_0004;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL basic_req1 got %b want 1", mem_req); end
        next_cycle();
        pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b want 0", id_valid); end
        next_cycle();
        mem_rdata = 32'h0010_0093;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL basic_v0 got %b want 1", id_valid); end
        n_cmp++; if (id_pc !== 64'h8000_0000) begin n_err++; $display("FAIL basic_pc0 got %h want 80000000", id_pc); end
        n_cmp++; if (id_inst !== 32'h0000_0013) begin n_err++; $display("FAIL basic_inst0 got %h want 00000013", id_inst); end
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL basic_v1 got %b want 1", id_valid); end
        n_cmp++; if (id_pc !== 64'h8000_0004) begin n_err++; $display("FAIL basic_pc1 got %h want 80000004", id_pc); end
        n_cmp++; if (id_inst !== 32'h0010_0093) begin n_err++; $display("FAIL basic_inst1 got %h want 00100093", id_inst); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL basic_end_valid got %b want 0", id_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_end_empty got %b want 1", empty); end
        next_cycle();
    endtask

    task automatic test_full();
        do_reset();
        mem_gnt = 1; id_ready = 0;
        for (int i = 0; i < 5; i++) begin
            pc_valid = 1; pc_addr = 64'h8000_0000 + 64'(4 * i);
            mem_rvalid = (i > 0); mem_rdata = 32'hC0DE_0000 + 32'(i - 1);
            @(negedge clk);
            if (i < 4) begin
                n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL full_req%0d got %b want 1", i, mem_req); end
            end else begin
                n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_req_blocked got %b want 0", mem_req); end
                n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL full_rdy_blocked got %b want 0", pc_ready); end
                n_cmp++; if (id_pc !== 64'h8000_0000) begin n_err++; $display("FAIL full_head_pc got %h want 80000000", id_pc); end
            end
            next_cycle();
        end
        mem_rvalid = 0; id_ready = 1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle_req got %b want 0", mem_req); end
        n_cmp++; if (id_pc !== 64'h8000_0000) begin n_err++; $display("FAIL full_hold_pc got %h want 80000000", id_pc); end
        n_cmp++; if (id_inst !== 32'hC0DE_0000) begin n_err++; $display("FAIL full_hold_inst got %h want c0de0000", id_inst); end
        next_cycle();
        id_ready = 0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL full_credit_back got %b want 1", mem_req); end
        n_cmp++; if (id_pc !== 64'h8000_0004) begin n_err++; $display("FAIL full_next_pc got %h want 80000004", id_pc); end
        next_cycle();
        pc_valid = 0;
    endtask

    task automatic test_flush_drop();
        do_reset();
        mem_gnt = 1; pc_valid = 1; pc_addr = 64'h8000_0000;
        next_cycle();
        pc_addr = 64'h8000_0004;
        next_cycle();
        pc_addr = 64'h8000_0008; flush = 1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fl_req got %b want 0", mem_req); end
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL fl_rdy got %b want 0", pc_ready); end
        next_cycle();
        flush = 0; pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_0001;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop1_valid got %b want 0", id_valid); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fl_drop_empty got %b want 0", empty); end
        next_cycle();
        mem_rdata = 32'hDEAD_0002;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop2_valid got %b want 0", id_valid); end
        next_cycle();
        mem_rvalid = 0; pc_valid = 1; pc_addr = 64'h8000_0100;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_after_valid got %b want 0", id_valid); end
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fl_new_req got %b want 1", mem_req); end
        next_cycle();
        pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0517;
        next_cycle();
        mem_rvalid = 0; id_ready = 1;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL fl_new_valid got %b want 1", id_valid); end
        n_cmp++; if (id_pc !== 64'h8000_0100) begin n_err++; $display("FAIL fl_new_pc got %h want 80000100", id_pc); end
        n_cmp++; if (id_inst !== 32'h0000_0517) begin n_err++; $display("FAIL fl_new_inst got %h want 00000517", id_inst); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fl_end_empty got %b want 1", empty); end
        next_cycle();
    endtask

    task automatic test_no_use();
        do_reset();
        pc_valid = 1; pc_no_use = 1; mem_gnt = 1; pc_addr = 64'h8000_0200;
        @(negedge clk);
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL nu_rdy_gnt got %b want 1", pc_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL nu_req_gnt got %b want 0", mem_req); end
        next_cycle();
        mem_gnt = 0;
        @(negedge clk);
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL nu_rdy_nognt got %b want 1", pc_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL nu_req_nognt got %b want 0", mem_req); end
        next_cycle();
        pc_valid = 0; pc_no_use = 0;
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL nu_empty got %b want 1", empty); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL nu_id_valid got %b want 0", id_valid); end
        next_cycle();
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        mem_gnt = 1; pc_valid = 1; pc_addr = 64'h8000_0000;
        next_cycle();
        pc_addr = 64'h8000_0004;
        next_cycle();
        pc_addr = 64'h8000_0008; mem_rvalid = 1; mem_rdata = 32'hAAAA_0000;
        next_cycle();
        pc_valid = 0; flush = 1; id_ready = 1; mem_rdata = 32'hAAAA_0001;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fr_flush_valid got %b want 0", id_valid); end
        next_cycle();
        flush = 0; mem_rdata = 32'hAAAA_0002;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fr_drop_valid got %b want 0", id_valid); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fr_drop_empty got %b want 0", empty); end
        next_cycle();
        mem_rvalid = 0; pc_valid = 1; pc_addr = 64'h8000_0300;
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fr_empty got %b want 1", empty); end
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fr_new_req got %b want 1", mem_req); end
        next_cycle();
        pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'h5555_0001;
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL fr_new_valid got %b want 1", id_valid); end
        n_cmp++; if (id_pc !== 64'h8000_0300) begin n_err++; $display("FAIL fr_new_pc got %h want 80000300", id_pc); end
        n_cmp++; if (id_inst !== 32'h5555_0001) begin n_err++; $display("FAIL fr_new_inst got %h want 55550001", id_inst); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_gnt = 1; pc_valid = 1; pc_addr = 64'h8000_0000;
        next_cycle();
        pc_addr = 64'h8000_0004; mem_rvalid = 1; mem_rdata = 32'hBBBB_0000;
        next_cycle();
        pc_addr = 64'h8000_0008; mem_rvalid = 0;
        next_cycle();
        rst = 1; pc_addr = 64'h8000_000C;
        @(negedge clk);
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL rm_rdy got %b want 0", pc_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rm_req got %b want 0", mem_req); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", id_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_empty got %b want 1", empty); end
        next_cycle();
        rst = 0; pc_valid = 0;
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_post_empty got %b want 1", empty); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rm_post_valid got %b want 0", id_valid); end
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL rm_post_rdy got %b want 0", pc_ready); end
        next_cycle();
        pc_valid = 1; pc_addr = 64'h8000_0000;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_req_again got %b want 1", mem_req); end
        next_cycle();
        pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        next_cycle();
        mem_rvalid = 0; id_ready = 1;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL rm_fetch_valid got %b want 1", id_valid); end
        n_cmp++; if (id_pc !== 64'h8000_0000) begin n_err++; $display("FAIL rm_fetch_pc got %h want 80000000", id_pc); end
        n_cmp++; if (id_inst !== 32'h0000_0013) begin n_err++; $display("FAIL rm_fetch_inst got %h want 00000013", id_inst); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_end_empty got %b want 1", empty); end
        next_cycle();
    endtask

    task automatic test_random();
        bit            offer, nu, rv, credit, e_req, e_rdy, e_idv, e_empty;
        logic [CW-1:0] addr, next_pc, tpc;
        logic [IW-1:0] tinst;
        int            used, filled, pending;
        do_reset();
        offer = 0; nu = 0; addr = '0; next_pc = 64'h8000_1000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst   = ($urandom_range(0, 249) == 0);
            flush = !rst && ($urandom_range(0, 29) == 0);
            if (!offer && $urandom_range(0, 9) < 7) begin
                offer = 1; nu = ($urandom_range(0, 5) == 0); addr = next_pc; next_pc = next_pc + 4;
            end
            pc_valid = offer; pc_no_use = offer & nu; pc_addr = addr;
            mem_gnt  = ($urandom_range(0, 9) < 6);
            rv = !rst && memq.size() > 0 && ($urandom_range(0, 9) < 6);
            mem_rvalid = rv; mem_rdata = rv ? memq[0] : '0;
            id_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            used    = m_pc.size();
            filled  = m_inst.size();
            pending = used - filled;
            credit  = (used + m_drop) < DEPTH;
            e_req   = pc_valid && !pc_no_use && credit && !flush && !rst;
            e_rdy   = !rst && !flush && pc_valid && (pc_no_use || (credit && mem_gnt));
            e_idv   = (filled > 0) && !flush && !rst;
            e_empty = rst || (used == 0 && m_drop == 0);
            n_cmp++; if (mem_req !== e_req) begin n_err++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, mem_req, e_req); end
            n_cmp++; if (pc_ready !== e_rdy) begin n_err++; $display("FAIL rnd_rdy cyc %0d got %b want %b", cyc, pc_ready, e_rdy); end
            n_cmp++; if (id_valid !== e_idv) begin n_err++; $display("FAIL rnd_idv cyc %0d got %b want %b", cyc, id_valid, e_idv); end
            n_cmp++; if (empty !== e_empty) begin n_err++; $display("FAIL rnd_empty cyc %0d got %b want %b", cyc, empty, e_empty); end
            if (e_req) begin
                n_cmp++; if (mem_addr !== pc_addr) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, mem_addr, pc_addr); end
            end
            if (e_idv) begin
                n_cmp++; if (id_pc !== m_pc[0]) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, id_pc, m_pc[0]); end
                n_cmp++; if (id_inst !== m_inst[0]) begin n_err++; $display("FAIL rnd_inst cyc %0d got %h want %h", cyc, id_inst, m_inst[0]); end
            end
            @(posedge clk);
            if (rst) begin
                m_pc.delete(); m_inst.delete(); m_drop = 0; memq.delete(); offer = 0;
            end else begin
                if (rv) tinst = memq.pop_front();
                if (e_req && mem_gnt) memq.push_back($urandom());
                if (flush) begin
                    m_drop = m_drop + pending - int'(rv);
                    if (m_drop < 0) m_drop = 0;
                    m_pc.delete(); m_inst.delete();
                    offer = 0; next_pc = {32'h0, $urandom()} & ~64'h3;
                end else begin
                    if (e_idv && id_ready) begin tpc = m_pc.pop_front(); tinst = m_inst.pop_front(); end
                    if (rv) begin
                        if (m_drop > 0) m_drop--;
                        else if (pending > 0) m_inst.push_back(mem_rdata);
                    end
                    if (e_req && mem_gnt) m_pc.push_back(pc_addr);
                    if (e_rdy) offer = 0;
                end
            end
            #1;
        end
        rst = 0;
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst = 1;
        test_reset();
        test_basic();
        test_full();
        test_flush_drop();
        test_no_use();
        test_flush_rvalid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Fetch-side consumer of the PC generator's address stream. It accepts fetch addresses, issues them to instruction memory over a request/grant bus, and collects in-order, variable-latency responses into a small slot queue. It delivers {pc, instruction} pairs to ID with a valid/ready handshake. An EX redirect (flush) discards all queued and in-flight fetches.

Parameters:
DEPTH, 4, number of queue slots; power of two, >= 2; also the maximum of queued plus in-flight plus to-be-dropped fetches
CPU_WIDTH, 64, PC/address width
INST_WIDTH, 32, instruction width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pc_valid  in  1  PC generator offers an address
pc_addr  in  CPU_WIDTH  offered fetch address
pc_no_use  in  1  offered address is a bubble; consumed, never fetched
pc_ready  out  1  offer accepted this cycle
flush  in  1  EX redirect; kill all queued and in-flight fetches
mem_req  out  1  fetch request to instruction memory
mem_addr  out  CPU_WIDTH  request address
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  in-order response valid
mem_rdata  in  INST_WIDTH  response instruction
id_valid  out  1  instruction available to ID
id_pc  out  CPU_WIDTH  PC of the head slot
id_inst  out  INST_WIDTH  instruction of the head slot
id_ready  in  1  ID consumes the head slot
empty  out  1  no slots allocated and nothing in flight

Behaviour:
- State:
  - slot array of {pc, inst}
  - pointers alloc_ptr, fill_ptr, rd_ptr, each log2(DEPTH)+1 bits, wrapping naturally
  - drop_cnt, log2(DEPTH)+1 bits
  - derived: used = alloc_ptr - rd_ptr; pending = alloc_ptr - fill_ptr
- credit = (used + drop_cnt) < DEPTH.
- Issue:
  - mem_req = pc_valid & ~pc_no_use & credit & ~flush & ~rst.
  - mem_addr = pc_addr, combinational.
  - On mem_req & mem_gnt: write pc_addr into slot[alloc_ptr], alloc_ptr++.
- PC handshake:
  - pc_ready = ~rst & ~flush & pc_valid & (pc_no_use | (credit & mem_gnt)).
  - A pc_no_use offer is acknowledged with no slot allocated and no request.
  - While no grant arrives, the PC generator holds pc_addr stable.
- Response:
  - On mem_rvalid with drop_cnt > 0: drop_cnt--, data discarded.
  - On mem_rvalid with drop_cnt = 0 and pending > 0: slot[fill_ptr].inst <= mem_rdata, fill_ptr++.
  - On mem_rvalid with nothing in flight: ignored (protocol error, no state change).
- Output:
  - id_valid = (fill_ptr != rd_ptr) & ~flush & ~rst.
  - id_pc and id_inst come from slot[rd_ptr].
  - On id_valid & id_ready: rd_ptr++.
  - Latency: rvalid in cycle N gives id_valid in cycle N+1 (registered slot).
  - Under back-pressure, outputs hold stable.
- Simultaneous events:
  - Issue, fill and pop may all occur in one cycle; the credit check uses pre-update counts. A pop does not free credit until the next cycle.
- Full: when used + drop_cnt = DEPTH, mem_req=0 and pc_ready=0 unless pc_no_use=1.
- Flush (priority over everything except rst):
  - No issue and no pop that cycle.
  - alloc_ptr, fill_ptr and rd_ptr <= 0.
  - drop_cnt <= drop_cnt + pending - mem_rvalid, saturating at 0.
  - Normal operation resumes the next cycle.
- Reset:
  - All pointers and drop_cnt <= 0; slot contents are don't-care.
  - While rst=1: pc_ready, mem_req and id_valid are 0, empty=1.
  - Instruction memory is reset in the same cycle, so no responses survive reset.
- empty = (used == 0) & (drop_cnt == 0).

Test Plan:
1. After reset, offer 0x8000_0000 and 0x8000_0004 with mem_gnt=1; respond 0x00000013 and 0x00100093 two cycles later, id_ready=1 -> ID receives the pairs in order, each one cycle after its rvalid; empty=1 at the end.
2. DEPTH=4, id_ready=0, mem_gnt=1, rvalid immediate -> after 4 grants: pc_ready=0, mem_req=0, id_pc=0x8000_0000 held. Raise id_ready one cycle -> mem_req=1 on the following cycle.
3. Two fetches in flight, then flush -> drop_cnt=2; the next two rvalids are discarded with id_valid=0; new fetch 0x8000_0100 returning 0x00000517 is delivered correctly.
4. pc_valid=1, pc_no_use=1 -> pc_ready=1, mem_req=0, used unchanged, no id output.
5. Flush in the same cycle as rvalid and id_ready=1 with 1 filled + 2 pending -> no ID transfer; drop_cnt=1; exactly one later rvalid dropped.
6. rst asserted mid-operation with 3 slots used -> next cycle empty=1, id_valid=0, pc_ready=0; after release, a fetch of 0x8000_0000 completes normally.
